// File: rtl/nf_lsu_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : nf_lsu_sb_if
//  Description : Data-memory bus between the nanoFOX LSU (master) and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nf_lsu_sb_if;
   logic [31:0] addr_dm;
   logic [31:0] rd_dm;
   logic [31:0] wd_dm;
   logic        we_dm;
   logic [1:0]  size_dm;
   logic        req_dm;
   logic        req_ack_dm;

   modport master (
      output addr_dm,
      output wd_dm,
      output we_dm,
      output size_dm,
      output req_dm,
      input  rd_dm,
      input  req_ack_dm
   );

   modport slave (
      input  addr_dm,
      input  wd_dm,
      input  we_dm,
      input  size_dm,
      input  req_dm,
      output rd_dm,
      output req_ack_dm
   );
endinterface
`default_nettype wire

// File: rtl/nf_lsu_sb.sv
`default_nettype none
// ============================================================================
//  Module      : nf_lsu_sb
//  Description : Load/store unit with an in-order store buffer that retires
//                stores in the background. Define NF_LSU_FWD_EN to enable
//                store-to-load forwarding from word entries in the buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module nf_lsu_sb #(
   parameter int SB_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [31:0]               result_imem,
   input  logic [31:0]               rd2_imem,
   input  logic                      we_dm_imem,
   input  logic                      rf_src_imem,
   input  logic [1:0]                size_dm_imem,
   input  logic                      unsigned_imem,
   output logic [31:0]               rd_dm_iwb,
   output logic                      load_valid_iwb,
   output logic                      lsu_busy,
   output logic                      lsu_err,
   output logic [$clog2(SB_DEPTH):0] sb_count,
   nf_lsu_sb_if.master               bus
);
   localparam int c_AW = $clog2(SB_DEPTH);
   localparam int c_CW = c_AW + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LD_WAIT = 2'd1,
      LD_REQ  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [31:0]       r_sb_addr [SB_DEPTH];
   logic [31:0]       r_sb_data [SB_DEPTH];
   logic [1:0]        r_sb_size [SB_DEPTH];
   logic [c_AW-1:0]   r_wr_ptr;
   logic [c_AW-1:0]   r_rd_ptr;
   logic [c_CW-1:0]   r_count;

   logic [31:0]       r_ld_addr;
   logic [1:0]        r_ld_size;
   logic              r_ld_uns;

   logic [31:0]       r_last_addr;
   logic [31:0]       r_last_wd;
   logic [1:0]        r_last_size;

   logic [31:0]       r_rd;
   logic              r_lv;
   logic              r_err;

   logic              w_req;
   logic              w_misal;
   logic              w_push;
   logic              w_pop;
   logic              w_ld_start;
   logic              w_empty;
   logic              w_full;
   logic              w_drain;
   logic              w_ld_req;
   logic              w_fwd_hit;
   logic [31:0]       w_fwd_data;
   logic [31:0]       w_st_data;

   function automatic logic [31:0] f_extract(input logic [31:0] d,
                                             input logic [1:0]  a,
                                             input logic [1:0]  sz,
                                             input logic        uns);
      logic [31:0] sh;
      sh = d >> {a, 3'b000};
      case (sz)
         2'b00:   f_extract = uns ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
         2'b01:   f_extract = uns ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
         default: f_extract = d;
      endcase
   endfunction

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == c_CW'(SB_DEPTH));
   assign lsu_busy = (r_state != IDLE) || w_full;

   assign w_misal = (size_dm_imem == 2'b11) ||
                    ((size_dm_imem == 2'b01) && result_imem[0]) ||
                    ((size_dm_imem == 2'b10) && (result_imem[1:0] != 2'b00));

   // A combined store+load request is treated as a store.
   assign w_req      = (we_dm_imem || rf_src_imem) && !lsu_busy;
   assign w_push     = w_req && we_dm_imem && !w_misal;
   assign w_ld_start = w_req && !we_dm_imem && rf_src_imem && !w_misal;
   assign w_pop      = w_drain && bus.req_ack_dm;

   always_comb begin
      case (size_dm_imem)
         2'b00:   w_st_data = {4{rd2_imem[7:0]}};
         2'b01:   w_st_data = {2{rd2_imem[15:0]}};
         default: w_st_data = rd2_imem;
      endcase
   end

`ifdef NF_LSU_FWD_EN
   logic            w_fwd_match;
   logic            w_fwd_word;
   logic [c_AW-1:0] w_idx;

   // Walk oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      w_fwd_match = 1'b0;
      w_fwd_word  = 1'b0;
      w_fwd_data  = '0;
      w_idx       = r_rd_ptr;
      for (int i = 0; i < SB_DEPTH; i++) begin
         w_idx = r_rd_ptr + c_AW'(i);
         if ((c_CW'(i) < r_count) && (r_sb_addr[w_idx][31:2] == r_ld_addr[31:2])) begin
            w_fwd_match = 1'b1;
            w_fwd_word  = (r_sb_size[w_idx] == 2'b10);
            w_fwd_data  = r_sb_data[w_idx];
         end
      end
   end

   assign w_fwd_hit = (r_state == LD_WAIT) && w_fwd_match && w_fwd_word;
`else
   assign w_fwd_hit  = 1'b0;
   assign w_fwd_data = '0;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_ld_req     = 1'b0;
      bus.req_dm   = 1'b0;
      bus.we_dm    = 1'b0;
      bus.addr_dm  = r_last_addr;
      bus.wd_dm    = r_last_wd;
      bus.size_dm  = r_last_size;
      case (r_state)
         IDLE: begin
            if (w_ld_start)
               w_state_nxt = LD_WAIT;
         end
         LD_WAIT: begin
            if (w_fwd_hit)
               w_state_nxt = IDLE;
            else if (w_empty)
               w_state_nxt = LD_REQ;
         end
         LD_REQ: begin
            w_ld_req = 1'b1;
            if (bus.req_ack_dm)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      w_drain = !w_empty && (r_state != LD_REQ);
      if (w_drain) begin
         bus.req_dm  = 1'b1;
         bus.we_dm   = 1'b1;
         bus.addr_dm = r_sb_addr[r_rd_ptr];
         bus.wd_dm   = r_sb_data[r_rd_ptr];
         bus.size_dm = r_sb_size[r_rd_ptr];
      end else if (w_ld_req) begin
         bus.req_dm  = 1'b1;
         bus.addr_dm = r_ld_addr;
         bus.size_dm = r_ld_size;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_sb_addr[r_wr_ptr] <= result_imem;
         r_sb_data[r_wr_ptr] <= w_st_data;
         r_sb_size[r_wr_ptr] <= size_dm_imem;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_ld_addr   <= '0;
         r_ld_size   <= '0;
         r_ld_uns    <= 1'b0;
         r_last_addr <= '0;
         r_last_wd   <= '0;
         r_last_size <= '0;
         r_rd        <= '0;
         r_lv        <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_req && w_misal;
         r_lv    <= 1'b0;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
         if (w_ld_start) begin
            r_ld_addr <= result_imem;
            r_ld_size <= size_dm_imem;
            r_ld_uns  <= unsigned_imem;
         end
         // The idle bus keeps presenting whatever was last requested.
         if (bus.req_dm) begin
            r_last_addr <= bus.addr_dm;
            r_last_wd   <= bus.wd_dm;
            r_last_size <= bus.size_dm;
         end
         if (w_ld_req && bus.req_ack_dm) begin
            r_rd <= f_extract(bus.rd_dm, r_ld_addr[1:0], r_ld_size, r_ld_uns);
            r_lv <= 1'b1;
         end else if (w_fwd_hit) begin
            r_rd <= f_extract(w_fwd_data, r_ld_addr[1:0], r_ld_size, r_ld_uns);
            r_lv <= 1'b1;
         end
      end
   end

   assign rd_dm_iwb      = r_rd;
   assign load_valid_iwb = r_lv;
   assign lsu_err        = r_err;
   assign sb_count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_nf_lsu_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nf_lsu_sb
//  Description : Scoreboard bench for nf_lsu_sb: directed stores/loads with
//                bus and load results checked by a free-running monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nf_lsu_sb;
   localparam int SB_DEPTH = 4;
   localparam int CW       = $clog2(SB_DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   result_imem;
   logic [31:0]   rd2_imem;
   logic          we_dm_imem;
   logic          rf_src_imem;
   logic [1:0]    size_dm_imem;
   logic          unsigned_imem;
   wire  [31:0]   rd_dm_iwb;
   wire           load_valid_iwb;
   wire           lsu_busy;
   wire           lsu_err;
   wire  [CW-1:0] sb_count;

   logic          ack_en;
   logic [31:0]   rdata;

   nf_lsu_sb_if bus ();

   assign bus.req_ack_dm = bus.req_dm & ack_en;
   assign bus.rd_dm      = rdata;

   nf_lsu_sb #(.SB_DEPTH(SB_DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .result_imem    (result_imem),
      .rd2_imem       (rd2_imem),
      .we_dm_imem     (we_dm_imem),
      .rf_src_imem    (rf_src_imem),
      .size_dm_imem   (size_dm_imem),
      .unsigned_imem  (unsigned_imem),
      .rd_dm_iwb      (rd_dm_iwb),
      .load_valid_iwb (load_valid_iwb),
      .lsu_busy       (lsu_busy),
      .lsu_err        (lsu_err),
      .sb_count       (sb_count),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [1:0]  size;
   } bus_t;

   typedef struct {
      logic [31:0] data;
      logic        fwd;
   } ld_t;

   bus_t exp_bus [$];
   ld_t  exp_ld  [$];
   int   exp_err;
   int   n_tests;
   int   n_fail;
   int   cyc;
   int   last_ld_ack;
   bus_t mb;
   ld_t  ml;

`ifdef NF_LSU_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every bus handshake, load result and error pulse is matched
   // against what the stimulus queued.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.req_dm && !bus.we_dm)
            chk("ld_req_sb_empty", 32'(sb_count), 32'd0);
         if (bus.req_dm && bus.req_ack_dm) begin
            if (!bus.we_dm)
               last_ld_ack = cyc;
            if (exp_bus.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL bus_unexpected: got addr 0x%08h we %0b, expected no transfer",
                        bus.addr_dm, bus.we_dm);
            end else begin
               mb = exp_bus.pop_front();
               chk("bus_we",   32'(bus.we_dm),   32'(mb.we));
               chk("bus_addr", bus.addr_dm,      mb.addr);
               chk("bus_size", 32'(bus.size_dm), 32'(mb.size));
               if (mb.we)
                  chk("bus_wd", bus.wd_dm, mb.wd);
            end
         end
         if (load_valid_iwb) begin
            if (exp_ld.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL ld_unexpected: got 0x%08h, expected no load result", rd_dm_iwb);
            end else begin
               ml = exp_ld.pop_front();
               chk("ld_data", rd_dm_iwb, ml.data);
               if (!ml.fwd)
                  chk("ld_latency", 32'(cyc), 32'(last_ld_ack + 1));
            end
         end
         if (lsu_err) begin
            chk("err_expected", 32'(exp_err > 0), 32'd1);
            if (exp_err > 0)
               exp_err--;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic st, input logic ld, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic uns);
      int n;
      n = 0;
      we_dm_imem    = st;
      rf_src_imem   = ld;
      result_imem   = a;
      rd2_imem      = d;
      size_dm_imem  = sz;
      unsigned_imem = uns;
      while (lsu_busy && n < 200) begin
         tick();
         n++;
      end
      chk("issue_timeout", 32'(lsu_busy), 32'd0);
      tick();
      we_dm_imem  = 1'b0;
      rf_src_imem = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb_count != 0 || lsu_busy || exp_ld.size() != 0 || exp_bus.size() != 0) && n < 500) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(n < 500), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; ack_en = 1'b0; rdata = '0;
      result_imem = '0; rd2_imem = '0; we_dm_imem = 1'b0; rf_src_imem = 1'b0;
      size_dm_imem = '0; unsigned_imem = 1'b0; exp_err = 0;
      repeat (3) tick();
      chk("rst_rd",    rd_dm_iwb,              32'd0);
      chk("rst_lv",    32'(load_valid_iwb),    32'd0);
      chk("rst_busy",  32'(lsu_busy),          32'd0);
      chk("rst_err",   32'(lsu_err),           32'd0);
      chk("rst_count", 32'(sb_count),          32'd0);
      chk("rst_addr",  bus.addr_dm,            32'd0);
      chk("rst_wd",    bus.wd_dm,              32'd0);
      chk("rst_we",    32'(bus.we_dm),         32'd0);
      chk("rst_size",  32'(bus.size_dm),       32'd0);
      chk("rst_req",   32'(bus.req_dm),        32'd0);
      reset = 1'b0;
      tick();

      // Byte store then signed/unsigned byte loads from the same lane.
      ack_en = 1'b1;
      exp_bus.push_back('{1'b1, 32'h0000_0103, 32'h8080_8080, 2'b00});
      issue(1'b1, 1'b0, 32'h0000_0103, 32'h1234_5680, 2'b00, 1'b0);
      chk("st_count", 32'(sb_count),    32'd1);
      chk("st_req",   32'(bus.req_dm),  32'd1);
      chk("st_wd",    bus.wd_dm,        32'h8080_8080);
      chk("st_size",  32'(bus.size_dm), 32'd0);
      wait_idle();
      rdata = 32'h8012_3456;
      exp_bus.push_back('{1'b0, 32'h0000_0103, 32'h0, 2'b00});
      exp_ld.push_back('{32'hFFFF_FF80, 1'b0});
      issue(1'b0, 1'b1, 32'h0000_0103, 32'h0, 2'b00, 1'b0);
      chk("ld_t1_busy", 32'(lsu_busy),   32'd1);
      chk("ld_t1_req",  32'(bus.req_dm), 32'd0);
      tick();
      chk("ld_t2_req",  32'(bus.req_dm), 32'd1);
      chk("ld_t2_we",   32'(bus.we_dm),  32'd0);
      chk("ld_t2_busy", 32'(lsu_busy),   32'd1);
      tick();
      chk("ld_t3_valid", 32'(load_valid_iwb), 32'd1);
      chk("ld_t3_data",  rd_dm_iwb,           32'hFFFF_FF80);
      wait_idle();
      exp_bus.push_back('{1'b0, 32'h0000_0103, 32'h0, 2'b00});
      exp_ld.push_back('{32'h0000_0080, 1'b0});
      issue(1'b0, 1'b1, 32'h0000_0103, 32'h0, 2'b00, 1'b1);
      wait_idle();

      // Full buffer: five stores with the bus stalled.
      ack_en = 1'b0;
      for (int i = 0; i < 5; i++)
         exp_bus.push_back('{1'b1, 32'h300 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'b10});
      for (int i = 0; i < 4; i++)
         issue(1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'b10, 1'b0);
      chk("full_count", 32'(sb_count), 32'd4);
      chk("full_busy",  32'(lsu_busy), 32'd1);
      we_dm_imem = 1'b1; result_imem = 32'h310; rd2_imem = 32'hA000_0004; size_dm_imem = 2'b10;
      repeat (3) tick();
      chk("full_hold_count", 32'(sb_count), 32'd4);
      chk("full_hold_req0",  bus.addr_dm,   32'h300);
      ack_en = 1'b1;
      issue(1'b1, 1'b0, 32'h310, 32'hA000_0004, 2'b10, 1'b0);
      wait_idle();

      // Load waits behind three unrelated stores.
      ack_en = 1'b0;
      rdata  = 32'hCAFE_F00D;
      for (int i = 0; i < 3; i++)
         exp_bus.push_back('{1'b1, 32'h400 + 32'(4 * i), 32'h4000_0000 + 32'(i), 2'b10});
      exp_bus.push_back('{1'b0, 32'h500, 32'h0, 2'b10});
      exp_ld.push_back('{32'hCAFE_F00D, 1'b0});
      for (int i = 0; i < 3; i++)
         issue(1'b1, 1'b0, 32'h400 + 32'(4 * i), 32'h4000_0000 + 32'(i), 2'b10, 1'b0);
      issue(1'b0, 1'b1, 32'h500, 32'h0, 2'b10, 1'b0);
      repeat (3) tick();
      chk("behind_busy",  32'(lsu_busy),  32'd1);
      chk("behind_count", 32'(sb_count),  32'd3);
      chk("behind_we",    32'(bus.we_dm), 32'd1);
      ack_en = 1'b1;
      wait_idle();

      // Half load hitting a queued word store.
      ack_en = 1'b0;
      rdata  = 32'hDEAD_BEEF;
      exp_bus.push_back('{1'b1, 32'h200, 32'hDEAD_BEEF, 2'b10});
      if (!FWD)
         exp_bus.push_back('{1'b0, 32'h202, 32'h0, 2'b01});
      exp_ld.push_back('{32'h0000_DEAD, FWD});
      issue(1'b1, 1'b0, 32'h200, 32'hDEAD_BEEF, 2'b10, 1'b0);
      issue(1'b0, 1'b1, 32'h202, 32'h0, 2'b01, 1'b1);
      tick();
      if (FWD) begin
         chk("fwd_valid", 32'(load_valid_iwb), 32'd1);
         chk("fwd_data",  rd_dm_iwb,           32'h0000_DEAD);
         chk("fwd_count", 32'(sb_count),       32'd1);
      end else begin
         tick();
         chk("nofwd_valid", 32'(load_valid_iwb), 32'd0);
         chk("nofwd_busy",  32'(lsu_busy),       32'd1);
      end
      ack_en = 1'b1;
      wait_idle();

      // Misaligned word load and half store are dropped.
      exp_err = 1;
      issue(1'b0, 1'b1, 32'h101, 32'h0, 2'b10, 1'b0);
      chk("mis_ld_err",   32'(lsu_err),      32'd1);
      chk("mis_ld_busy",  32'(lsu_busy),     32'd0);
      chk("mis_ld_count", 32'(sb_count),     32'd0);
      chk("mis_ld_req",   32'(bus.req_dm),   32'd0);
      tick();
      chk("mis_ld_pulse", 32'(lsu_err),      32'd0);
      exp_err = exp_err + 1;
      issue(1'b1, 1'b0, 32'h103, 32'h5555, 2'b01, 1'b0);
      chk("mis_st_err",   32'(lsu_err),      32'd1);
      chk("mis_st_busy",  32'(lsu_busy),     32'd0);
      chk("mis_st_count", 32'(sb_count),     32'd0);
      chk("mis_st_req",   32'(bus.req_dm),   32'd0);
      chk("mis_rd_keep",  rd_dm_iwb,         32'h0000_DEAD);
      tick();

      // Reset with two stores queued and a request outstanding.
      ack_en = 1'b0;
      issue(1'b1, 1'b0, 32'h600, 32'h6666_6666, 2'b10, 1'b0);
      issue(1'b1, 1'b0, 32'h604, 32'h6666_6667, 2'b10, 1'b0);
      chk("pre_rst_count", 32'(sb_count),   32'd2);
      chk("pre_rst_req",   32'(bus.req_dm), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_async_req",   32'(bus.req_dm), 32'd0);
      chk("rst_async_count", 32'(sb_count),   32'd0);
      tick();
      reset  = 1'b0;
      ack_en = 1'b1;
      repeat (5) tick();
      chk("post_rst_count", 32'(sb_count),   32'd0);
      chk("post_rst_req",   32'(bus.req_dm), 32'd0);
      exp_bus.push_back('{1'b1, 32'h700, 32'h7777_7777, 2'b10});
      issue(1'b1, 1'b0, 32'h700, 32'h7777_7777, 2'b10, 1'b0);
      wait_idle();
      repeat (3) tick();

      chk("bus_q_empty", 32'(exp_bus.size()), 32'd0);
      chk("ld_q_empty",  32'(exp_ld.size()),  32'd0);
      chk("err_pending", 32'(exp_err),        32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/nf_lsu_sb.md
# nf_lsu_sb

Parametrised load/store unit with an in-order store buffer, placed between the memory stage of the nanoFOX pipeline and the data-memory bus.
- Stores retire to memory in the background, so the pipeline stalls only when the buffer is full.
- Loads are byte-lane aligned and sign/zero extended before write-back.
- Misaligned accesses are dropped and flagged.
- Optional store-to-load forwarding lets loads bypass a non-empty buffer.

## Interface
Parameters:
- SB_DEPTH, 4, store-buffer entries; power of two, ≥ 2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- result_imem  in  32  access address from memory stage
- rd2_imem  in  32  store data (unshifted, in low bits)
- we_dm_imem  in  1  store request
- rf_src_imem  in  1  load request
- size_dm_imem  in  2  00 byte, 01 half, 10 word, 11 illegal
- unsigned_imem  in  1  1 = zero-extend load, 0 = sign-extend
- rd_dm_iwb  out  32  aligned, extended load result
- load_valid_iwb  out  1  one-cycle pulse: rd_dm_iwb newly written
- lsu_busy  out  1  stall request to pipeline
- lsu_err  out  1  one-cycle pulse: misaligned/illegal access dropped
- sb_count  out  $clog2(SB_DEPTH)+1  occupied entries
- addr_dm  out  32  bus address
- rd_dm  in  32  bus read data
- wd_dm  out  32  bus write data, lane-replicated
- we_dm  out  1  bus write enable
- size_dm  out  2  bus access size
- req_dm  out  1  bus request
- req_ack_dm  in  1  bus acknowledge

## Operation
- **Acceptance:** a request is accepted in any cycle with (we_dm_imem || rf_src_imem) && !lsu_busy. If both are set, the access is treated as a store.
- **Misalignment:** half with addr[0]=1, word with addr[1:0]≠0, or size 11 → lsu_err pulses next cycle. Nothing is enqueued or loaded, no stall results, and rd_dm_iwb is unchanged.
- **Store enqueue:** stores push {addr, lane-replicated data, size} into the FIFO.
  - Byte data is replicated ×4 from rd2[7:0].
  - Half data is replicated ×2 from rd2[15:0].
  - Word data is passed through.
- **Drain:** while the FIFO is non-empty and the FSM is not in LD_REQ, the head entry drives addr_dm/wd_dm/size_dm with we_dm=1 and req_dm=1. These are held stable until req_ack_dm, and the entry pops on the ack cycle.
- **Simultaneous push and pop:** sb_count is unchanged. The full FIFO raises lsu_busy, so overflow is impossible.
- **lsu_busy** = (state ≠ IDLE) || (sb_count == SB_DEPTH).
- **FSM states:** IDLE, LD_WAIT, LD_REQ.
  - IDLE → LD_WAIT on an accepted aligned load. The load's address, size and sign are latched.
  - LD_WAIT → IDLE on a forwarding hit (see Configuration).
  - LD_WAIT → LD_REQ when the FIFO is empty.
  - Otherwise the FSM stays in LD_WAIT while stores drain.
  - LD_REQ: req_dm=1, we_dm=0, with the latched addr and size. On req_ack_dm, rd_dm_iwb is written, load_valid_iwb pulses next cycle, and the FSM returns to IDLE.
- **Load extraction:** lane data = rd_dm >> 8·addr[1:0]. Bytes take bits [7:0] and halves take bits [15:0]. The result is sign- or zero-extended per unsigned_imem; words are passed unchanged.
- **Bus idle:** when the bus is idle, req_dm=0 and we_dm=0. addr_dm, wd_dm and size_dm hold their last values.

## Timing
- **Reset values:** rd_dm_iwb=0, load_valid_iwb=0, lsu_busy=0, lsu_err=0, sb_count=0, addr_dm=0, wd_dm=0, we_dm=0, size_dm=0, req_dm=0. FSM=IDLE.
- **Store with empty FIFO,** accepted in cycle T: sb_count=1 and req_dm=1 in T+1. The store pops on the ack edge.
- **Load with empty FIFO,** accepted in T: LD_WAIT in T+1, LD_REQ with req_dm=1 in T+2. With ack in T+2, load_valid_iwb=1 in T+3. lsu_busy is high in T+1..T+2.
- **Slow bus:** req_ack_dm may arrive any number of cycles late. The request stays asserted and unchanged until it does.
- **Reset mid-transaction:** the FIFO is flushed, req_dm drops asynchronously, and any in-flight load is lost. The bus slave must tolerate an abandoned request.

## Configuration
- **NF_LSU_FWD_EN defined:** in LD_WAIT, the FIFO is searched for the youngest entry with the same addr[31:2].
  - If that entry is a word store, the FSM forwards: rd_dm_iwb is written from the entry data via the extraction rule, load_valid_iwb pulses the next cycle, and the FSM goes to IDLE with no bus access.
  - If the youngest match is sub-word, or there is no match and the FIFO is non-empty, the FSM waits for drain.
  - Forwarded-load latency is accept T → load_valid_iwb in T+2.
- **Not defined:** loads always wait in LD_WAIT until the FIFO is empty. No comparators are synthesised.

## Test plan
- **Byte store/load sign:** store byte 0x80 to 0x103, then load byte signed from 0x103.
  - Required: wd_dm=0x80808080 and size_dm=00.
  - Required: rd_dm_iwb=0xFFFFFF80; with unsigned_imem=1, 0x00000080.
- **Full buffer:** issue SB_DEPTH+1 back-to-back stores with req_ack_dm held low.
  - Required: sb_count=4 and lsu_busy=1.
  - Required: the 5th store is accepted only after the first ack, and all five appear on the bus in issue order.
- **Load behind stores:** 3 queued word stores, then a word load to an unmatched address.
  - Required: no load req_dm until sb_count=0; load_valid_iwb follows the ack by one cycle.
- **Forwarding:** store word 0xDEADBEEF to 0x200, then load half unsigned from 0x202 with the bus stalled.
  - With NF_LSU_FWD_EN: rd_dm_iwb=0x0000DEAD two cycles after acceptance, with no load bus request.
  - Without it: the same value is returned after the drain and load request.
- **Misaligned:** word load at 0x101, then half store at 0x103.
  - Required: each gives an lsu_err pulse, with no FIFO change, no bus request, and lsu_busy=0.
- **Reset mid-operation:** assert reset with 2 entries queued and req_dm=1.
  - Required: req_dm=0 and sb_count=0 immediately.
  - Required: after release, no stale entry reaches the bus.
